// File: rtl/instruction_encoder_pkg.sv
// instruction_encoder_pkg: shared RV32 field constants, op_select encoding and the encode helper
package instruction_encoder_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int REGADDR_WIDTH = 5;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam logic [6:0] OPC_OP = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_MUL = 3'd0;
  localparam logic [2:0] F3_SLT = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_DIV = 3'd4;
  localparam logic [2:0] F3_DIVU = 3'd5;
  localparam logic [2:0] F3_REM = 3'd6;
  localparam logic [2:0] F3_REMU = 3'd7;
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_SUB = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;
  typedef enum logic [3:0] {
    OP_ADDI  = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_MUL   = 4'd3,
    OP_DIV   = 4'd4,
    OP_DIVU  = 4'd5,
    OP_REM   = 4'd6,
    OP_REMU  = 4'd7,
    OP_SLTI  = 4'd8,
    OP_SLTIU = 4'd9,
    OP_SLT   = 4'd10,
    OP_SLTU  = 4'd11
  } op_sel_e;
  typedef struct packed {
    logic ok;
    logic [INSTRUCTION_WIDTH-1:0] word;
  } enc_t;
  function automatic logic is_itype(input logic [3:0] op);
    return op == OP_ADDI || op == OP_SLTI || op == OP_SLTIU;
  endfunction
  function automatic logic is_supported(input logic [3:0] op);
    return op <= OP_SLTU;
  endfunction
  // A 32-bit value fits a 12-bit signed immediate when bits 31..11 are all copies of the sign
  function automatic logic imm_fits(input logic [DATA_WIDTH-1:0] imm);
    return (&imm[31:11]) | ~(|imm[31:11]);
  endfunction
  function automatic logic [2:0] funct3_of(input logic [3:0] op);
    case (op)
      OP_DIV:            return F3_DIV;
      OP_DIVU:           return F3_DIVU;
      OP_REM:            return F3_REM;
      OP_REMU:           return F3_REMU;
      OP_SLT, OP_SLTI:   return F3_SLT;
      OP_SLTU, OP_SLTIU: return F3_SLTU;
      OP_MUL:            return F3_MUL;
      default:           return F3_ADD_SUB;
    endcase
  endfunction
  function automatic logic [6:0] funct7_of(input logic [3:0] op);
    return op == OP_SUB ? F7_SUB : (op >= OP_MUL && op <= OP_REMU) ? F7_MULDIV : F7_BASE;
  endfunction
  function automatic enc_t encode(
    input logic [3:0] op,
    input logic [REGADDR_WIDTH-1:0] rd,
    input logic [REGADDR_WIDTH-1:0] rs1,
    input logic [REGADDR_WIDTH-1:0] rs2,
    input logic [DATA_WIDTH-1:0] imm
  );
    enc_t e;
    e.ok = is_supported(op) && (!is_itype(op) || imm_fits(imm));
    e.word = is_itype(op) ? {imm[11:0], rs1, funct3_of(op), rd, OPC_OP_IMM}
                          : {funct7_of(op), rs2, rs1, funct3_of(op), rd, OPC_OP};
    return e;
  endfunction
endpackage

// File: rtl/instruction_fifo.sv
// instruction_fifo: power-of-two circular buffer with occupancy counter and zero output when empty
module instruction_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign rdata = empty ? '0 : mem[rptr];
  // Pointers wrap naturally at DEPTH; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // Storage needs no reset: empty masks stale contents
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: encodes RV32 ALU/M requests into a FIFO and flags rejected requests
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         op_valid,
  output logic                         op_ready,
  input  logic [3:0]                   op_select,
  input  logic [REGADDR_WIDTH-1:0]     rd,
  input  logic [REGADDR_WIDTH-1:0]     rs1,
  input  logic [REGADDR_WIDTH-1:0]     rs2,
  input  logic [DATA_WIDTH-1:0]        immediateVal,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [INSTRUCTION_WIDTH-1:0] instr_out,
  output logic                         error,
  output logic [7:0]                   errorCount
);
  enc_t enc;
  logic accept, reject, full, empty;
  assign enc = encode(op_select, rd, rs1, rs2, immediateVal);
  assign op_ready = ~full;
  assign accept = op_valid & op_ready;
  assign reject = accept & ~enc.ok;
  assign instr_valid = ~empty;
  instruction_fifo #(
    .WIDTH(INSTRUCTION_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(accept & enc.ok),
    .pop(instr_valid & instr_ready),
    .wdata(enc.word),
    .rdata(instr_out),
    .full(full),
    .empty(empty)
  );
  // Error pulses the cycle after a rejected acceptance; counter saturates at 255
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error <= 1'b0;
      errorCount <= 8'd0;
    end else begin
      error <= reject;
      if (reject && errorCount != 8'hFF) errorCount <= errorCount + 8'd1;
    end
  end
endmodule
